// File: rtl/fusion_mac.sv
// rtl/fusion_mac.sv - bit-brick fusion multiply-accumulate with runtime lane widths
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   beat handshake for in_data/wt_data and their mode bits
//   in_data, wt_data    packed operand lanes, lane 0 at LSB
//   in_width            input lane width in bits (illegal codes mean DATA_W)
//   weight_width        weight lane width in bits (illegal codes mean DATA_W)
//   s_in, s_weight      lanes are two's complement
//   in_last             final beat of the current dot product
//   out_valid/out_ready result handshake
//   out_data            accumulated result, modulo 2^ACC_W
module fusion_mac #(
  parameter int SLICES = 2,
  parameter int ACC_W  = 24,
  localparam int DATA_W = 2 * SLICES,
  localparam int WC_W   = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [WC_W-1:0]   in_width,
  input  logic [WC_W-1:0]   weight_width,
  input  logic              s_in,
  input  logic              s_weight,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int PW = 2 * DATA_W + 2;
  localparam int NB = SLICES * SLICES;

  // Number of 2-bit slices per lane for a width code; anything that is not a
  // power of two in 2..DATA_W falls back to one full-width lane.
  function automatic int slices_per_lane(input logic [WC_W-1:0] code);
    int c;
    c = int'(code);
    if (c >= 2 && c <= DATA_W && (c & (c - 1)) == 0) return c / 2;
    return SLICES;
  endfunction

  logic             s1_valid_q, s1_last_q, s1_sgn_q;
  logic [PW-1:0]    brick_q [NB];
  logic [PW-1:0]    brick_d [NB];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             adv;

  assign adv       = !(out_valid_q && !out_ready);
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Brick array: every input slice meets every weight slice. Each slice only
  // knows its position inside its own lane, so lane boundaries fall out of the
  // shift amount and the sum over all bricks equals sum(in lanes)*sum(wt lanes).
  always_comb begin
    int                spl_i, spl_w;
    int                in_pos [SLICES];
    int                wt_pos [SLICES];
    logic signed [2:0] in_sl  [SLICES];
    logic signed [2:0] wt_sl  [SLICES];
    logic signed [5:0] prod;
    spl_i = slices_per_lane(in_width);
    spl_w = slices_per_lane(weight_width);
    prod  = '0;
    for (int k = 0; k < SLICES; k++) begin
      in_pos[k] = k & (spl_i - 1);
      wt_pos[k] = k & (spl_w - 1);
      // Only the top slice of a signed lane carries the sign.
      in_sl[k]  = {s_in && (in_pos[k] == spl_i - 1) && in_data[2*k+1], in_data[2*k +: 2]};
      wt_sl[k]  = {s_weight && (wt_pos[k] == spl_w - 1) && wt_data[2*k+1], wt_data[2*k +: 2]};
    end
    for (int a = 0; a < SLICES; a++) begin
      for (int b = 0; b < SLICES; b++) begin
        prod = in_sl[a] * wt_sl[b];
        brick_d[a*SLICES+b] = PW'(prod) << (2 * (in_pos[a] + wt_pos[b]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sgn_q   <= 1'b0;
      for (int i = 0; i < NB; i++) brick_q[i] <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      s1_sgn_q   <= s_in | s_weight;
      brick_q    <= brick_d;
    end
  end

  logic [PW-1:0]    beat_sum;
  logic [ACC_W-1:0] beat_ext, acc_sum;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NB; i++) beat_sum = beat_sum + brick_q[i];
  end

  // Unsigned beats are zero-extended; an extra 0 MSB keeps them positive.
  assign beat_ext = ACC_W'($signed({s1_sgn_q & beat_sum[PW-1], beat_sum}));
  assign acc_sum  = acc_q + beat_ext;

  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      if (out_ready) out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fusion_mac.sv
// tb/tb_fusion_mac.sv - randomized and directed bench for fusion_mac
module tb_fusion_mac;
  localparam int SLICES = 2;
  localparam int DATA_W = 4;
  localparam int ACC_W  = 24;
  localparam int WC_W   = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data, wt_data;
  logic [WC_W-1:0]   in_width, weight_width;
  logic              s_in, s_weight, in_last;
  logic              out_valid, out_ready;
  logic [ACC_W-1:0]  out_data;

  fusion_mac #(.SLICES(SLICES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wt_data(wt_data),
    .in_width(in_width), .weight_width(weight_width),
    .s_in(s_in), .s_weight(s_weight), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: value of each lane as an integer, summed over lanes.
  function automatic longint lane_sum(input logic [DATA_W-1:0] d, input logic [WC_W-1:0] code,
                                      input logic s);
    int          w;
    longint      sum, v;
    logic [63:0] dd;
    w = int'(code);
    if (!(w >= 2 && w <= DATA_W && (w & (w - 1)) == 0)) w = DATA_W;
    dd  = 64'(d);
    sum = 0;
    for (int l = 0; l < DATA_W / w; l++) begin
      v = longint'((dd >> (l * w)) & ((64'd1 << w) - 64'd1));
      if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      sum = sum + v;
    end
    return sum;
  endfunction

  longint      macc;
  logic [63:0] expq [$];
  logic [63:0] acc_mask;

  initial acc_mask = (64'd1 << ACC_W) - 64'd1;

  always @(negedge clk) begin
    if (!rst_n) begin
      macc = 0;
      expq.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_result_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) check("sb_out_data", 64'(out_data), expq.pop_front());
      end
      if (in_valid && in_ready) begin
        macc = macc + lane_sum(in_data, in_width, s_in) * lane_sum(wt_data, weight_width, s_weight);
        if (in_last) begin
          expq.push_back(64'(macc) & acc_mask);
          macc = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [3:0] d, input logic [3:0] w, input int iw, input int ww,
                      input logic si, input logic sw, input logic last);
    int n;
    in_data = d; wt_data = w;
    in_width = 3'(iw); weight_width = 3'(ww);
    s_in = si; s_weight = sw; in_last = last;
    in_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n >= 100) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [63:0] exp);
    int n;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd2);
    check(tag, 64'(out_data), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; wt_data = '0;
    in_width = 3'd4; weight_width = 3'd4; s_in = 1'b0; s_weight = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    send(4'hF, 4'hF, 4, 4, 1'b0, 1'b0, 1'b1); wait_result("u_full", 64'd225);
    send(4'h8, 4'h3, 4, 4, 1'b1, 1'b1, 1'b1); wait_result("s_full", 64'hFFFFE8);
    send(4'h8, 4'h3, 4, 4, 1'b0, 1'b1, 1'b1); wait_result("s_full_uin", 64'd24);
    send(4'hD, 4'h9, 2, 2, 1'b0, 1'b0, 1'b1); wait_result("lane2_u", 64'd12);
    send(4'hF, 4'h5, 2, 2, 1'b1, 1'b1, 1'b1); wait_result("lane2_s", 64'hFFFFFC);
    send(4'h6, 4'h5, 2, 4, 1'b0, 1'b0, 1'b1); wait_result("mixed_w", 64'd15);
    send(4'hF, 4'h2, 3, 0, 1'b0, 1'b0, 1'b1); wait_result("illegal_w", 64'd30);

    // 10 + 20 + (-5) with bubbles between beats
    send(4'h2, 4'h5, 4, 4, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    send(4'h4, 4'h5, 4, 4, 1'b0, 1'b0, 1'b0);
    send(4'hF, 4'h5, 4, 4, 1'b1, 1'b0, 1'b1); wait_result("accum", 64'd25);
    send(4'h1, 4'h3, 4, 4, 1'b0, 1'b0, 1'b1); wait_result("acc_cleared", 64'd3);

    // Backpressure
    out_ready = 1'b0;
    send(4'hF, 4'hF, 4, 4, 1'b0, 1'b0, 1'b1);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_result_seen", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    in_data = 4'h2; wt_data = 4'h3; in_width = 3'd4; weight_width = 3'd4;
    s_in = 1'b0; s_weight = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data", 64'(out_data), 64'd225);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_result("bp_next", 64'd6);

    // Reset mid-group discards partial accumulation
    send(4'h2, 4'h5, 4, 4, 1'b0, 1'b0, 1'b0);
    send(4'h4, 4'h5, 4, 4, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4'h1, 4'h7, 4, 4, 1'b0, 1'b0, 1'b1); wait_result("after_rst", 64'd7);

    // Randomized traffic, checked by the scoreboard
    for (int c = 0; c < 800; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      in_data      = 4'($urandom);
      wt_data      = 4'($urandom);
      in_width     = 3'($urandom_range(0, 7));
      weight_width = 3'($urandom_range(0, 7));
      s_in         = 1'($urandom);
      s_weight     = 1'($urandom);
      in_last      = ($urandom_range(0, 3) == 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_empty", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
